// File: rtl/ll_pkg.sv
// Shared types and constants for the linked-list blocks: node layout,
// pointer/data widths and the walker FSM encoding.
package ll_pkg;

  localparam int unsigned PTR_W    = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 1 << PTR_W;
  localparam logic [PTR_W-1:0] NULL_PTR = '1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  next;
  } node_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

endpackage

// File: rtl/ll_node_mem.sv
// Node table: flop array with one write port and one combinational read port.
// Reset clears every node to data 0 / next NULL_PTR.
module ll_node_mem #(
  parameter int unsigned DATA_W   = ll_pkg::DATA_W,
  parameter int unsigned PTR_W    = ll_pkg::PTR_W,
  parameter int unsigned DEPTH    = 1 << PTR_W,
  parameter logic [PTR_W-1:0] NULL_PTR = PTR_W'(DEPTH - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  wr_next,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W-1:0]  rd_next
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  next_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        next_q[i] <= NULL_PTR;
      end
    end else if (wr_en) begin
      data_q[wr_addr] <= wr_data;
      next_q[wr_addr] <= wr_next;
    end
  end

  // Read sees the pre-write contents when addresses collide.
  assign rd_data = data_q[rd_addr];
  assign rd_next = next_q[rd_addr];

endmodule

// File: rtl/ll_walker.sv
// Follows next pointers from each accepted head pointer and emits one output
// beat per node; flags end of list, empty heads and hop-limit (cycle) errors.
module ll_walker #(
  parameter int unsigned DATA_W   = ll_pkg::DATA_W,
  parameter int unsigned PTR_W    = ll_pkg::PTR_W,
  parameter int unsigned DEPTH    = 1 << PTR_W,
  parameter logic [PTR_W-1:0] NULL_PTR = PTR_W'(DEPTH - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_W-1:0]  in_ptr,
  input  logic              in_ptr_vld,
  output logic              in_ptr_rdy,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  wr_next,
  output logic [DATA_W-1:0] out_data,
  output logic [PTR_W-1:0]  out_ptr,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_last,
  output logic              out_empty,
  output logic              out_err
);

  localparam logic [PTR_W-1:0] HOP_MAX = PTR_W'(DEPTH - 1);

  ll_pkg::state_e    state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [PTR_W-1:0]  out_ptr_q, out_ptr_d;
  logic              out_last_q, out_last_d;
  logic              out_empty_q, out_empty_d;
  logic              out_err_q, out_err_d;
  logic [PTR_W-1:0]  cur_next_q, cur_next_d;
  logic [PTR_W-1:0]  hops_q, hops_d;

  logic [PTR_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [PTR_W-1:0]  rd_next;
  logic              load;
  logic [PTR_W-1:0]  hop_nxt;
  logic              at_limit;

  ll_node_mem #(
    .DATA_W   (DATA_W),
    .PTR_W    (PTR_W),
    .DEPTH    (DEPTH),
    .NULL_PTR (NULL_PTR)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_next (wr_next),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_next (rd_next)
  );

  assign rd_addr  = (state_q == ll_pkg::IDLE) ? in_ptr : cur_next_q;
  assign at_limit = (hop_nxt == HOP_MAX);

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ptr_d   = out_ptr_q;
    out_last_d  = out_last_q;
    out_empty_d = out_empty_q;
    out_err_d   = out_err_q;
    cur_next_d  = cur_next_q;
    hops_d      = hops_q;
    load        = 1'b0;
    hop_nxt     = '0;

    case (state_q)
      ll_pkg::IDLE: begin
        if (in_ptr_vld) begin
          state_d = ll_pkg::SEND;
          if (in_ptr == NULL_PTR) begin
            out_data_d  = '0;
            out_ptr_d   = NULL_PTR;
            out_last_d  = 1'b1;
            out_empty_d = 1'b1;
            out_err_d   = 1'b0;
            hops_d      = '0;
          end else begin
            load    = 1'b1;
            hop_nxt = PTR_W'(1);
          end
        end
      end
      ll_pkg::SEND: begin
        if (out_rdy) begin
          if (out_last_q) begin
            state_d = ll_pkg::IDLE;
          end else begin
            load    = 1'b1;
            hop_nxt = hops_q + 1'b1;
          end
        end
      end
      default: state_d = ll_pkg::IDLE;
    endcase

    // Shared node load for both the head and each follow-on hop.
    if (load) begin
      out_data_d  = rd_data;
      out_ptr_d   = rd_addr;
      cur_next_d  = rd_next;
      hops_d      = hop_nxt;
      out_empty_d = 1'b0;
      out_last_d  = (rd_next == NULL_PTR) | at_limit;
      out_err_d   = at_limit & (rd_next != NULL_PTR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ll_pkg::IDLE;
      out_data_q  <= '0;
      out_ptr_q   <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
      out_err_q   <= 1'b0;
      cur_next_q  <= '0;
      hops_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ptr_q   <= out_ptr_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
      out_err_q   <= out_err_d;
      cur_next_q  <= cur_next_d;
      hops_q      <= hops_d;
    end
  end

  assign in_ptr_rdy = (state_q == ll_pkg::IDLE);
  assign out_vld    = (state_q == ll_pkg::SEND);
  assign out_data   = out_data_q;
  assign out_ptr    = out_ptr_q;
  assign out_last   = out_last_q;
  assign out_empty  = out_empty_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_ll_walker.sv
// Scoreboard bench for ll_walker: a reference node-table model predicts each
// walk's beats, which the monitor compares against accepted output beats.
module tb_ll_walker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_ptr = '0;
  logic       in_ptr_vld = 1'b0;
  logic       in_ptr_rdy;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] wr_next = '0;
  logic [7:0] out_data;
  logic [3:0] out_ptr;
  logic       out_vld;
  logic       out_rdy = 1'b0;
  logic       out_last;
  logic       out_empty;
  logic       out_err;

  ll_walker dut (
    .clk        (clk),
    .rst        (rst),
    .in_ptr     (in_ptr),
    .in_ptr_vld (in_ptr_vld),
    .in_ptr_rdy (in_ptr_rdy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_next    (wr_next),
    .out_data   (out_data),
    .out_ptr    (out_ptr),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_last   (out_last),
    .out_empty  (out_empty),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat packing: {ptr[3:0], data[7:0], last, empty, err}
  logic [14:0] sb [$];
  logic [7:0]  mdata [16];
  logic [3:0]  mnext [16];

  function automatic logic [14:0] cur_beat();
    return {out_ptr, out_data, out_last, out_empty, out_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mdata[i] = '0;
      mnext[i] = 4'hF;
    end
  endtask

  task automatic push_walk(input logic [3:0] head);
    logic [3:0] p;
    logic [3:0] n;
    logic       last;
    logic       err;
    int         hops;
    if (head == 4'hF) begin
      sb.push_back({4'hF, 8'h00, 1'b1, 1'b1, 1'b0});
    end else begin
      p = head;
      hops = 1;
      forever begin
        n    = mnext[p];
        last = (n == 4'hF) || (hops == 15);
        err  = (hops == 15) && (n != 4'hF);
        sb.push_back({p, mdata[p], last, 1'b0, err});
        if (last) break;
        p = n;
        hops++;
      end
    end
  endtask

  task automatic write_node(input logic [3:0] a, input logic [7:0] d, input logic [3:0] n);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_next = n;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mdata[a] = d;
    mnext[a] = n;
  endtask

  task automatic send_head(input logic [3:0] head);
    for (int i = 0; i < 20 && !in_ptr_rdy; i++) begin
      @(posedge clk); #1;
    end
    in_ptr = head; in_ptr_vld = 1'b1;
    @(posedge clk); #1;
    in_ptr_vld = 1'b0;
    check("first_beat_latency", {31'd0, out_vld}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (!(in_ptr_rdy && sb.size() == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("walk_done", {31'd0, in_ptr_rdy && sb.size() == 0}, 32'd1);
  endtask

  // Monitor: compare accepted beats against the scoreboard; check stall hold.
  logic        prev_stall = 1'b0;
  logic [14:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_vld) check("stall_hold", {17'd0, cur_beat()}, {17'd0, held});
      if (out_vld && out_rdy) begin
        check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) check("beat", {17'd0, cur_beat()}, {17'd0, sb.pop_front()});
      end
      prev_stall = out_vld && !out_rdy;
      held       = cur_beat();
    end
  end

  initial begin
    int n;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ptr_rdy", {31'd0, in_ptr_rdy}, 32'd1);
    check("rst_out_vld",    {31'd0, out_vld}, 32'd0);
    check("rst_beat",       {17'd0, cur_beat()}, 32'd0);

    out_rdy = 1'b1;
    push_walk(4'd0);
    send_head(4'd0);
    wait_idle(10, n);

    write_node(4'd3, 8'hA1, 4'd7);
    write_node(4'd7, 8'hB2, 4'd2);
    write_node(4'd2, 8'hC3, 4'hF);
    out_rdy = 1'b1;
    push_walk(4'd3);
    send_head(4'd3);
    wait_idle(10, n);
    check("no_bubble_cycles", n, 32'd3);

    out_rdy = 1'b0;
    push_walk(4'd3);
    send_head(4'd3);
    for (int i = 0; i < 6; i++) begin
      out_rdy = pat[i];
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    wait_idle(20, n);

    out_rdy = 1'b0;
    push_walk(4'hF);
    send_head(4'hF);
    check("busy_rdy_low", {31'd0, in_ptr_rdy}, 32'd0);
    in_ptr = 4'd4; in_ptr_vld = 1'b1;
    @(posedge clk); #1;
    in_ptr_vld = 1'b0;
    check("busy_ignores_head", {28'd0, out_ptr}, 32'hF);
    out_rdy = 1'b1;
    wait_idle(10, n);
    repeat (3) @(posedge clk);
    #1 check("no_extra_walk", {31'd0, out_vld}, 32'd0);

    write_node(4'd5, 8'h11, 4'd6);
    write_node(4'd6, 8'h22, 4'd5);
    out_rdy = 1'b1;
    push_walk(4'd5);
    send_head(4'd5);
    wait_idle(40, n);
    check("cycle_walk_cycles", n, 32'd15);

    out_rdy = 1'b0;
    send_head(4'd3);
    repeat (2) @(posedge clk);
    #1 write_node(4'd7, 8'hEE, 4'hF);
    push_walk(4'd3);
    check("stalled_beat_kept", {24'd0, out_data}, 32'hA1);
    out_rdy = 1'b1;
    wait_idle(10, n);

    out_rdy = 1'b0;
    push_walk(4'd3);
    send_head(4'd3);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("pending_beat2", {17'd0, cur_beat()}, {17'd0, 4'd7, 8'hEE, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
    check("rst_mid_walk_vld", {31'd0, out_vld}, 32'd0);
    check("rst_mid_walk_rdy", {31'd0, in_ptr_rdy}, 32'd1);
    out_rdy = 1'b1;
    push_walk(4'd3);
    send_head(4'd3);
    wait_idle(10, n);
    push_walk(4'd7);
    send_head(4'd7);
    wait_idle(10, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ll_walker.md
Name: ll_walker

Overview:
- Downstream consumer of the request generator's pointer stream (4-bit head pointer plus valid).
- Holds a 16-entry node table; each node has a data field and a next-pointer field.
- For each accepted head pointer, it follows the next pointers and emits one output beat per node until the list ends.
- Sits between the request generator and the display/LED logic on the demo board; its write port is loaded by a test harness or a future list-builder.

Parameters:
- DATA_W, 8, width of a node's data field
- PTR_W, 4, pointer width; must match the request generator's out_ptr
- DEPTH, 1<<PTR_W, number of nodes
- NULL_PTR, DEPTH-1, end-of-list marker; this node is never traversed

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- in_ptr  in  PTR_W  head pointer
- in_ptr_vld  in  1  head pointer valid
- in_ptr_rdy  out  1  walker idle, will accept a head pointer
- wr_en  in  1  node table write strobe
- wr_addr  in  PTR_W  node index
- wr_data  in  DATA_W  node data
- wr_next  in  PTR_W  node next pointer
- out_data  out  DATA_W  current node data
- out_ptr  out  PTR_W  index of the current node
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream accepts beat
- out_last  out  1  final beat of this walk
- out_empty  out  1  head was NULL_PTR; beat carries no node
- out_err  out  1  hop limit hit while the list has not ended (cycle in list)

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; out_vld=0; out_data, out_ptr, out_last, out_empty, out_err all 0.
  - Hop counter cleared.
  - Every node: data=0, next=NULL_PTR.
  - Reset mid-walk abandons the walk immediately; no further beats.
- Node table:
  - Flop array with combinational read.
  - wr_en writes {wr_data, wr_next} at the clk edge, independent of walker state.
  - A read in the same cycle as a write to the same address returns old contents.
  - Writes never alter a beat already held in the output register.
- FSM states: IDLE, SEND.
- IDLE:
  - in_ptr_rdy=1, out_vld=0.
  - On in_ptr_vld & in_ptr_rdy:
    - If in_ptr==NULL_PTR: load an empty beat (out_empty=1, out_last=1, out_data=0, out_ptr=NULL_PTR). Go to SEND.
    - Otherwise: load out_data=mem[in_ptr].data, out_ptr=in_ptr, cur_next=mem[in_ptr].next, hops=1. Go to SEND.
  - First out_vld rises the cycle after acceptance (latency 1).
- SEND:
  - in_ptr_rdy=0; out_vld=1.
  - Outputs hold stable while out_rdy=0.
  - On out_rdy with out_last=1: go to IDLE. in_ptr_rdy returns 1 the next cycle, so there is a one-cycle gap between walks.
  - On out_rdy with out_last=0: load node cur_next the same edge (hops+1), with no bubble between beats.
- Last and error flags (computed when a node is loaded):
  - out_last = (node.next==NULL_PTR) | (hops==DEPTH-1).
  - out_err = (hops==DEPTH-1) & (node.next!=NULL_PTR).
  - The hop limit is DEPTH-1 because NULL_PTR is excluded, so the longest legal list has 15 nodes. Any longer walk implies a cycle.
- A node whose next field equals its own index is a cycle and hits the hop limit.
- Hop counter is PTR_W bits; it must not wrap, given the limit above.
- in_ptr_vld while busy is ignored; the request generator must hold it, per standard valid/ready rules.

Decomposition:
- Shared package ll_pkg:
  - PTR_W, DATA_W, NULL_PTR constants.
  - Node struct {data, next}.
  - FSM state enum.
- One sub-module ll_node_mem:
  - Flop array with 1 write and 1 async read port, plus reset-to-NULL init.
  - Reused later by the list-builder and free-list blocks.
- The walker FSM and output register live in ll_walker.

Test Plan:
- Reset, then check: in_ptr_rdy=1, out_vld=0, all outputs 0. Read of every node via a walk from head 0 gives a single beat with data 0, last=1.
- List: write 3→{0xA1,7}, 7→{0xB2,2}, 2→{0xC3,15}. Send in_ptr=3 with out_rdy=1. Expect 3 consecutive beats with (out_ptr, data) = (3,A1), (7,B2), (2,C3), last only on the third, first beat one cycle after acceptance.
- Same list with out_rdy toggling 1,0,0,1,0,1. Each beat holds stable through the stall; no beat is lost or duplicated.
- in_ptr=15: expect a single beat with out_empty=1, out_last=1, out_err=0. in_ptr_rdy must be 0 during SEND, and an in_ptr_vld pulse during SEND is not accepted.
- Cycle: write 5→{0x11,6}, 6→{0x22,5}. Walk from 5. Expect 15 beats alternating 11/22, with the 15th beat having out_last=1 and out_err=1.
- Write 7→{0xEE,15} during the stall on beat (3,A1), then a walk, then assert rst while beat 2 is pending. Expect:
  - Beat 2 reads EE with last=1.
  - Reset drops out_vld the next cycle, and the table returns to data 0 / next NULL.
